// File: rtl/barrel_ctrl_if.sv
// Stream and rotator-operand bundle for barrel_ctrl: command input, external
// rotator hookup, result output and FIFO occupancy.
interface barrel_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [3:0] in_amt;
  logic       in_dir;

  logic [7:0] br_data;
  logic [2:0] br_ctr;
  logic       br_dir;
  logic [7:0] br_out;

  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_wrap;

  logic [4:0] level;

  modport slave (
    input  in_valid, in_data, in_amt, in_dir, br_out, out_ready,
    output in_ready, br_data, br_ctr, br_dir, out_valid, out_data, out_wrap, level
  );

  modport master (
    output in_valid, in_data, in_amt, in_dir, br_out, out_ready,
    input  in_ready, br_data, br_ctr, br_dir, out_valid, out_data, out_wrap, level
  );
endinterface

// File: rtl/barrel_ctrl.sv
// Command FIFO feeding an external combinational rotator, with a single
// registered result stage using a valid/ready handshake on both sides.
module barrel_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  barrel_ctrl_if.slave  bus
);

  localparam int         PTR_W      = $clog2(DEPTH);
  localparam logic [4:0] FULL_LEVEL = 5'(DEPTH);

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] ctr;
    logic       dir;
    logic       wrap;
  } cmd_t;

  cmd_t             mem_q [DEPTH];
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]       level_q, level_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_wrap_q, out_wrap_d;
  logic             empty, push, pop, stage_free;

  assign head       = mem_q[rd_ptr_q];
  assign empty      = (level_q == 5'd0);
  assign stage_free = !out_valid_q || bus.out_ready;
  assign push       = bus.in_valid && bus.in_ready;
  assign pop        = stage_free && !empty;

  assign bus.in_ready  = (level_q != FULL_LEVEL);
  assign bus.br_data   = empty ? 8'h00 : head.data;
  assign bus.br_ctr    = empty ? 3'd0  : head.ctr;
  assign bus.br_dir    = empty ? 1'b0  : head.dir;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_wrap  = out_wrap_q;
  assign bus.level     = level_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_wrap_d  = out_wrap_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({push, pop})
      2'b10:   level_d = level_q + 5'd1;
      2'b01:   level_d = level_q - 5'd1;
      default: level_d = level_q;
    endcase

    if (stage_free) begin
      out_valid_d = !empty;
      if (!empty) begin
        out_data_d = bus.br_out;
        out_wrap_d = head.wrap;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_wrap_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_wrap_q  <= out_wrap_d;
    end
  end

  // NOTE: storage has no reset; level and pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= '{data: bus.in_data, ctr: bus.in_amt[2:0],
                           dir: bus.in_dir, wrap: bus.in_amt[3]};
    end
  end

endmodule

// File: tb/tb_barrel_ctrl.sv
// Directed bench for barrel_ctrl: supplies the rotator model and checks reset,
// rotation, backpressure, streaming, full-with-pop and mid-stream reset.
module tb_barrel_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  barrel_ctrl_if bif ();

  barrel_ctrl #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  // External rotator: 16-bit doubled word gives both rotations by shifting.
  logic [15:0] dd, rot_l, rot_r;
  always_comb begin
    dd         = {bif.br_data, bif.br_data};
    rot_l      = dd << bif.br_ctr;
    rot_r      = dd >> bif.br_ctr;
    bif.br_out = bif.br_dir ? rot_l[15:8] : rot_r[7:0];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [3:0] a, input logic dir);
    bif.in_valid = v;
    bif.in_data  = d;
    bif.in_amt   = a;
    bif.in_dir   = dir;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp_d;
    rst_n         = 1'b0;
    bif.out_ready = 1'b1;
    drive(1'b0, 8'h00, 4'd0, 1'b0);
    tick();
    tick();
    check("rst_level",     32'(bif.level), 32'd0);
    check("rst_out_valid", 32'(bif.out_valid), 32'd0);
    check("rst_in_ready",  32'(bif.in_ready), 32'd1);
    check("rst_out_data",  32'(bif.out_data), 32'h00);
    check("rst_out_wrap",  32'(bif.out_wrap), 32'd0);
    check("rst_br_data",   32'(bif.br_data), 32'h00);
    rst_n = 1'b1;
    tick();

    // Right rotate 0x81 by 1 -> 0xC0, two-edge latency.
    drive(1'b1, 8'h81, 4'd1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 4'd0, 1'b0);
    check("rr_level_n",     32'(bif.level), 32'd1);
    check("rr_valid_n",     32'(bif.out_valid), 32'd0);
    check("rr_br_data",     32'(bif.br_data), 32'h81);
    check("rr_br_ctr",      32'(bif.br_ctr), 32'd1);
    check("rr_br_dir",      32'(bif.br_dir), 32'd0);
    tick();
    check("rr_valid_n1",    32'(bif.out_valid), 32'd1);
    check("rr_data",        32'(bif.out_data), 32'hC0);
    check("rr_wrap",        32'(bif.out_wrap), 32'd0);
    check("rr_level_n1",    32'(bif.level), 32'd0);
    check("rr_br_idle",     32'(bif.br_data), 32'h00);
    tick();
    check("rr_valid_drop",  32'(bif.out_valid), 32'd0);

    // Left rotate then left rotate by 9 (effective 1, wrap set).
    drive(1'b1, 8'h81, 4'd1, 1'b1);
    tick();
    drive(1'b1, 8'h01, 4'd9, 1'b1);
    tick();
    drive(1'b0, 8'h00, 4'd0, 1'b0);
    check("rl_data",        32'(bif.out_data), 32'h03);
    check("rl_wrap",        32'(bif.out_wrap), 32'd0);
    check("rl_level",       32'(bif.level), 32'd1);
    check("rl9_br_ctr",     32'(bif.br_ctr), 32'd1);
    tick();
    check("rl9_data",       32'(bif.out_data), 32'h02);
    check("rl9_wrap",       32'(bif.out_wrap), 32'd1);
    check("rl9_valid",      32'(bif.out_valid), 32'd1);
    tick();

    // Backpressure: five pushes with the result stage stalled.
    bif.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 8'(i), 4'd0, 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 4'd0, 1'b0);
    check("bp_level",       32'(bif.level), 32'd4);
    check("bp_in_ready",    32'(bif.in_ready), 32'd0);
    check("bp_data",        32'(bif.out_data), 32'h01);
    check("bp_valid",       32'(bif.out_valid), 32'd1);
    tick();
    tick();
    check("bp_data_hold",   32'(bif.out_data), 32'h01);
    check("bp_level_hold",  32'(bif.level), 32'd4);

    // Full with simultaneous pop: push is refused, level drops to 3.
    bif.out_ready = 1'b1;
    drive(1'b1, 8'hAA, 4'd0, 1'b0);
    #1;
    check("full_in_ready",  32'(bif.in_ready), 32'd0);
    tick();
    drive(1'b0, 8'h00, 4'd0, 1'b0);
    check("full_pop_level", 32'(bif.level), 32'd3);
    check("drain_2",        32'(bif.out_data), 32'h02);
    for (int i = 3; i <= 5; i++) begin
      tick();
      check($sformatf("drain_%0d", i), 32'(bif.out_data), 32'(i));
      check($sformatf("drain_valid_%0d", i), 32'(bif.out_valid), 32'd1);
    end
    check("drain_level",    32'(bif.level), 32'd0);
    tick();
    check("drain_idle",     32'(bif.out_valid), 32'd0);

    // Streaming: 0x01 rotated left by i, one result per cycle.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'h01, 4'(i), 1'b1);
      tick();
      check($sformatf("st_level_%0d", i), 32'(bif.level), 32'd1);
      if (i >= 1) begin
        exp_d = 8'h01 << ((i - 1) % 8);
        check($sformatf("st_data_%0d", i - 1), 32'(bif.out_data), 32'(exp_d));
        check($sformatf("st_wrap_%0d", i - 1), 32'(bif.out_wrap), 32'((i - 1) >= 8));
        check($sformatf("st_valid_%0d", i - 1), 32'(bif.out_valid), 32'd1);
      end
    end
    drive(1'b0, 8'h00, 4'd0, 1'b0);
    tick();
    check("st_data_15",     32'(bif.out_data), 32'h80);
    check("st_wrap_15",     32'(bif.out_wrap), 32'd1);
    check("st_level_end",   32'(bif.level), 32'd0);
    tick();

    // Reset mid-stream with level 3 and a pending result.
    bif.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'h11 + i), 4'd0, 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 4'd0, 1'b0);
    check("mr_level_pre",   32'(bif.level), 32'd3);
    check("mr_valid_pre",   32'(bif.out_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mr_valid",       32'(bif.out_valid), 32'd0);
    check("mr_level",       32'(bif.level), 32'd0);
    check("mr_in_ready",    32'(bif.in_ready), 32'd1);
    check("mr_data",        32'(bif.out_data), 32'h00);
    bif.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mr_no_stale_%0d", i), 32'(bif.out_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
